// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int WORD     = 16;
  localparam int OP_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_idx_t;

  // Opcodes not listed here produce a zero result.
  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SHL   = 5'd5,
    OP_SHR   = 5'd6,
    OP_PASSX = 5'd7
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters of alu_arbiter.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int OPW   = OP_WIDTH
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = y[SHW-1:0];

  always_comb begin
    z = '0;
    case (op)
      OP_ADD:   z = x + y;
      OP_SUB:   z = x - y;
      OP_AND:   z = x & y;
      OP_OR:    z = x | y;
      OP_XOR:   z = x ^ y;
      OP_SHL:   z = x << shamt;
      OP_SHR:   z = x >> shamt;
      OP_PASSX: z = x;
      default:  z = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int OPW   = OP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_x0,
  input  logic [WIDTH-1:0] req_x1,
  input  logic [WIDTH-1:0] req_y0,
  input  logic [WIDTH-1:0] req_y1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  state_t           state, state_nx;
  req_idx_t         grant, win;
  logic             accept, complete;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] x_r, y_r, alu_z;

`ifdef ALU_ARB_FIXED_PRI_EN
  always_comb begin
    win = req_valid[0] ? 1'b0 : 1'b1;
  end
`else
  req_idx_t last_grant;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    if (&req_valid) win = ~last_grant;
    else            win = req_valid[0] ? 1'b0 : 1'b1;
  end
`endif

  // rst_n gates acceptance so req_ready stays low while reset is held.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (|req_valid)) begin
          accept         = 1'b1;
          req_ready[win] = 1'b1;
          state_nx       = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= '0;
      x_r      <= '0;
      y_r      <= '0;
      grant    <= 1'b0;
      rsp_z    <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        op_r  <= win ? req_op1 : req_op0;
        x_r   <= win ? req_x1  : req_x0;
        y_r   <= win ? req_y1  : req_y0;
        grant <= win;
      end
      if (state == EXEC) rsp_z <= alu_z;
      if (complete)      done_cnt <= done_cnt + 8'd1;
    end
  end

`ifndef ALU_ARB_FIXED_PRI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= win;
  end
`endif

  alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .op (op_r),
    .x  (x_r),
    .y  (y_r),
    .z  (alu_z)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter; honours ALU_ARB_FIXED_PRI_EN.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  req_op0, req_op1;
  logic [15:0] req_x0, req_x1, req_y0, req_y1, rsp_z;
  logic        busy;
  logic [7:0]  done_cnt;

  int total = 0;
  int bad = 0;
  int last_win = 1;
  int done_model = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_y0    (req_y0),
    .req_y1    (req_y1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Opcode numbering: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 pass x.
  function automatic logic [15:0] modelAlu(input int op, input longint x, input longint y);
    longint r;
    case (op)
      0: r = (x + y) % 65536;
      1: r = (x - y + 65536) % 65536;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (x * (longint'(1) << (y % 16))) % 65536;
      6: r = x / (longint'(1) << (y % 16));
      7: r = x;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic int pickWinner(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      return 0;
`else
      return 1 - last_win;
`endif
    end
    return v[0] ? 0 : 1;
  endfunction

  task automatic randomOperands();
    req_op0 = 5'($urandom_range(0, 8));
    req_op1 = 5'($urandom_range(0, 8));
    req_x0  = 16'($urandom);
    req_x1  = 16'($urandom);
    req_y0  = 16'($urandom);
    req_y1  = 16'($urandom);
  endtask

  // One full transaction starting just after a negedge with the DUT idle.
  task automatic applyStimulus(input logic [1:0] valid, input int hold);
    int w;
    logic [15:0] exp_z;
    logic [1:0] wmask;
    w = pickWinner(valid);
    wmask = (w == 0) ? 2'b01 : 2'b10;
    exp_z = (w == 0) ? modelAlu(int'(req_op0), req_x0, req_y0)
                     : modelAlu(int'(req_op1), req_x1, req_y1);
    req_valid = valid;
    #1 checkOutput("req_ready_grant", 32'(req_ready), 32'(wmask));
    last_win = w;
    @(negedge clk);
    req_valid = 2'b11;
    req_x0 = 16'hFFFF;
    req_x1 = 16'($urandom);
    req_y0 = 16'($urandom);
    req_y1 = 16'($urandom);
    #1;
    checkOutput("exec_req_ready", 32'(req_ready), 32'd0);
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rsp_ready = ~wmask;
    #1;
    checkOutput("resp_rsp_valid", 32'(rsp_valid), 32'(wmask));
    checkOutput("resp_rsp_z", 32'(rsp_z), 32'(exp_z));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'(wmask));
      checkOutput("hold_rsp_z", 32'(rsp_z), 32'(exp_z));
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
    end
    req_valid = 2'b00;
    rsp_ready = wmask;
    @(negedge clk);
    rsp_ready = 2'b00;
    done_model = (done_model + 1) % 256;
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("done_cnt", 32'(done_cnt), 32'(done_model));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    randomOperands();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_z", 32'(rsp_z), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed add, first edge after reset");
    req_op0 = 5'd0;
    req_x0  = 16'h0003;
    req_y0  = 16'h0004;
    applyStimulus(2'b01, 5);

    $display("[TB] ties held with both valid");
    for (int i = 0; i < 4; i++) begin
      randomOperands();
      applyStimulus(2'b11, 0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      randomOperands();
      applyStimulus(v, $urandom_range(0, 3));
    end

    $display("[TB] reset during EXEC");
    randomOperands();
    req_valid = 2'b10;
    #1 checkOutput("pre_rst_ready", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rsp_z", 32'(rsp_z), 32'd0);
    checkOutput("midrst_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_win = 1;
    done_model = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end
    rsp_ready = 2'b00;

    $display("[TB] tie after reset favours requester 0");
    randomOperands();
    applyStimulus(2'b11, 1);

    $display("[TB] counter wrap");
    for (int i = 1; i < 256; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      randomOperands();
      applyStimulus(v, 0);
    end
    checkOutput("done_cnt_wrap", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, 16, datapath word width (matches `WORD).
REQ-002 SHALL have parameter OPW, 5, ALU opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid.
REQ-006 SHALL have port req_ready  output  2  per-requester request accept.
REQ-007 SHALL have ports req_op0/req_op1  input  OPW  requester 0/1 ALUop.
REQ-008 SHALL have ports req_x0/req_x1, req_y0/req_y1  input  WIDTH  requester 0/1 operands.
REQ-009 SHALL have port rsp_valid  output  2  per-requester result valid.
REQ-010 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-011 SHALL have port rsp_z  output  WIDTH  registered ALU result.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port done_cnt  output  8  count of completed responses.

Function
REQ-014 SHALL share one alu instance between two requesters via FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-015 IDLE: if any req_valid, SHALL pick winner, pulse req_ready[winner] for that cycle only, latch op/x/y into operand regs, record grant, go EXEC; no valid -> stay IDLE.
REQ-016 req_ready SHALL be 0 in EXEC and RESP; requests are never accepted outside IDLE.
REQ-017 EXEC: SHALL capture the ALU output of the latched operands into rsp_z, go RESP (exactly one cycle).
REQ-018 RESP: SHALL drive rsp_valid[grant]=1, other bit 0; rsp_z stable; leave to IDLE only on cycle with rsp_ready[grant]=1.
REQ-019 Latency: request accepted at edge N -> rsp_valid high after edge N+2; peak throughput one op per 3 cycles.
REQ-020 rsp_ready on the non-granted bit SHALL be ignored.
REQ-021 done_cnt SHALL increment by 1 on each RESP->IDLE transition, wrapping 255 -> 0.
REQ-022 Round-robin (default): both valid in IDLE -> grant the requester not granted last; single valid -> that requester wins regardless of history.
REQ-023 Last-grant pointer SHALL update only on acceptance.
REQ-024 Operand changes on req_* after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, rsp_z=0, busy=0, done_cnt=0, last-grant pointer=1 (so requester 0 wins first tie).
REQ-026 Reset mid-EXEC or mid-RESP SHALL abandon the operation; no response is produced after release.
REQ-027 First acceptance possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRI_EN defined: requester 0 SHALL always win ties; pointer unused.
REQ-029 Macro undefined: round-robin per REQ-022.

Structure
REQ-030 Shared package SHALL hold WORD width, OPW, FSM state encoding (IDLE/EXEC/RESP) and requester index type.
REQ-031 SHALL instantiate existing alu as its single sub-module, driven only from latched operand regs.

Verification
REQ-032 Reset, req_valid=2'b01, op0=ADD, x0=16'h0003, y0=16'h0004 -> req_ready=2'b01 one cycle; rsp_valid=2'b01 after 2 more edges, rsp_z=16'h0007; rsp_ready=1 -> done_cnt=1.
REQ-033 req_valid=2'b11 held, rsp_ready=2'b11, round-robin build -> grants 0,1,0,1 in order; fixed-priority build -> 0,0,0,0.
REQ-034 In RESP hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_z stable, req_ready=0, busy=1 throughout.
REQ-035 Change x0 to 16'hFFFF one cycle after acceptance -> rsp_z still reflects original operands.
REQ-036 Assert rst_n=0 during EXEC -> outputs zero immediately; after release no rsp_valid without new request.
REQ-037 256 completed ops -> done_cnt reads 0.
